// File: rtl/user_dma_rr_arbiter.sv
// Two-channel round-robin DMA arbiter: read-request and write-data channels share the Tx engine.
// Optional per-channel watchdog enabled by defining USER_DMA_ARB_WDOG_EN.
module user_dma_rr_arbiter #(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 12,
  parameter int TAG_WIDTH   = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int DMA_LEN     = 5,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  // read request channel, slave side
  input  logic [NUM_SLAVES-1:0]            i_slave_dma_req,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] i_slave_dma_addr,
  input  logic [NUM_SLAVES*LEN_WIDTH-1:0]  i_slave_dma_len,
  input  logic [NUM_SLAVES*TAG_WIDTH-1:0]  i_slave_dma_tag,
  output logic [NUM_SLAVES-1:0]            o_slave_dma_ack,
  // write data channel, slave side
  input  logic [NUM_SLAVES-1:0]            i_slave_dma_data_avail,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] i_slave_dma_wr_addr,
  input  logic [NUM_SLAVES*DMA_LEN-1:0]    i_slave_dma_wr_len,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_slave_dma_data,
  output logic [NUM_SLAVES-1:0]            o_slave_dma_data_rd,
  output logic [NUM_SLAVES-1:0]            o_slave_dma_done,
  // read request channel, Tx engine side
  output logic                             o_dma_req,
  input  logic                             i_dma_ack,
  output logic [ADDR_WIDTH-1:0]            o_dma_req_addr,
  output logic [LEN_WIDTH-1:0]             o_dma_req_len,
  output logic [TAG_WIDTH-1:0]             o_dma_req_tag,
  // write data channel, Tx engine side
  output logic                             o_dma_data_avail,
  output logic [ADDR_WIDTH-1:0]            o_dma_wr_addr,
  output logic [DATA_WIDTH-1:0]            o_dma_data,
  output logic [DMA_LEN-1:0]               o_dma_len,
  input  logic                             i_dma_data_rd,
  input  logic                             i_dma_done,
  // status
  output logic [$clog2(NUM_SLAVES)-1:0]    o_rd_grant_id,
  output logic [$clog2(NUM_SLAVES)-1:0]    o_wr_grant_id,
  output logic                             o_rd_timeout,
  output logic                             o_wr_timeout
);

  localparam int SEL_W = $clog2(NUM_SLAVES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // First requester after 'last' in circular order; 'last' itself is checked at the end.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SLAVES-1:0] req,
                                              input logic [SEL_W-1:0]      last);
    logic [SEL_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_SLAVES; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_SLAVES) idx = idx - NUM_SLAVES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[SEL_W-1:0];
      end
    end
    return pick;
  endfunction

  state_t           r_rd_state, w_rd_state_next;
  state_t           r_wr_state, w_wr_state_next;
  logic [SEL_W-1:0] r_rd_sel, w_rd_sel_next, r_rd_last, w_rd_last_next;
  logic [SEL_W-1:0] r_wr_sel, w_wr_sel_next, r_wr_last, w_wr_last_next;
  logic [SEL_W-1:0] w_rd_pick, w_wr_pick;

  logic [NUM_SLAVES-1:0] w_rd_oh, w_wr_oh;
  logic                  w_rd_req_out, w_rd_ack_fire;
  logic                  w_wr_avail_out, w_wr_rd_fire, w_wr_done_fire;
  logic                  w_rd_wdog_hit, w_wr_wdog_hit;

  logic [ADDR_WIDTH-1:0] w_addr_arr    [NUM_SLAVES];
  logic [LEN_WIDTH-1:0]  w_len_arr     [NUM_SLAVES];
  logic [TAG_WIDTH-1:0]  w_tag_arr     [NUM_SLAVES];
  logic [ADDR_WIDTH-1:0] w_wr_addr_arr [NUM_SLAVES];
  logic [DMA_LEN-1:0]    w_wr_len_arr  [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] w_data_arr    [NUM_SLAVES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign w_addr_arr[gi]    = i_slave_dma_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_len_arr[gi]     = i_slave_dma_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign w_tag_arr[gi]     = i_slave_dma_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign w_wr_addr_arr[gi] = i_slave_dma_wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wr_len_arr[gi]  = i_slave_dma_wr_len[gi*DMA_LEN +: DMA_LEN];
      assign w_data_arr[gi]    = i_slave_dma_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_rd_oh[gi]       = (r_rd_sel == SEL_W'(gi));
      assign w_wr_oh[gi]       = (r_wr_sel == SEL_W'(gi));
    end
  endgenerate

  assign w_rd_pick = rr_pick(i_slave_dma_req, r_rd_last);
  assign w_wr_pick = rr_pick(i_slave_dma_data_avail, r_wr_last);

  // Read channel: a withdrawn request releases the grant, but a same-cycle ack takes priority.
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_sel_next   = r_rd_sel;
    w_rd_last_next  = r_rd_last;
    w_rd_req_out    = 1'b0;
    w_rd_ack_fire   = 1'b0;
    case (r_rd_state)
      ST_IDLE: begin
        if (|i_slave_dma_req) begin
          w_rd_sel_next   = w_rd_pick;
          w_rd_last_next  = w_rd_pick;
          w_rd_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_rd_req_out = |(i_slave_dma_req & w_rd_oh);
        if (i_dma_ack) begin
          w_rd_ack_fire   = 1'b1;
          w_rd_state_next = ST_IDLE;
        end else if (!w_rd_req_out || w_rd_wdog_hit) begin
          w_rd_state_next = ST_IDLE;
        end
      end
      default: w_rd_state_next = ST_IDLE;
    endcase
  end

  // Write channel: the grant holds until done, regardless of data_avail.
  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_sel_next   = r_wr_sel;
    w_wr_last_next  = r_wr_last;
    w_wr_avail_out  = 1'b0;
    w_wr_rd_fire    = 1'b0;
    w_wr_done_fire  = 1'b0;
    case (r_wr_state)
      ST_IDLE: begin
        if (|i_slave_dma_data_avail) begin
          w_wr_sel_next   = w_wr_pick;
          w_wr_last_next  = w_wr_pick;
          w_wr_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_wr_avail_out = |(i_slave_dma_data_avail & w_wr_oh);
        w_wr_rd_fire   = i_dma_data_rd;
        if (i_dma_done) begin
          w_wr_done_fire  = 1'b1;
          w_wr_state_next = ST_IDLE;
        end else if (w_wr_wdog_hit) begin
          w_wr_state_next = ST_IDLE;
        end
      end
      default: w_wr_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_state <= ST_IDLE;
      r_wr_state <= ST_IDLE;
      r_rd_sel   <= '0;
      r_wr_sel   <= '0;
      r_rd_last  <= SEL_W'(NUM_SLAVES - 1);
      r_wr_last  <= SEL_W'(NUM_SLAVES - 1);
    end else begin
      r_rd_state <= w_rd_state_next;
      r_wr_state <= w_wr_state_next;
      r_rd_sel   <= w_rd_sel_next;
      r_wr_sel   <= w_wr_sel_next;
      r_rd_last  <= w_rd_last_next;
      r_wr_last  <= w_wr_last_next;
    end
  end

`ifdef USER_DMA_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_rd_wdog, r_wr_wdog;
  logic              r_rd_timeout, r_wr_timeout;
  logic              w_rd_to_fire, w_wr_to_fire;

  // Counters sit at zero while idle, so they start from zero on every new grant.
  assign w_rd_wdog_hit = (r_rd_state == ST_BUSY) && (r_rd_wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign w_wr_wdog_hit = (r_wr_state == ST_BUSY) && (r_wr_wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign w_rd_to_fire  = w_rd_wdog_hit && !i_dma_ack && w_rd_req_out;
  assign w_wr_to_fire  = w_wr_wdog_hit && !i_dma_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_wdog    <= '0;
      r_wr_wdog    <= '0;
      r_rd_timeout <= 1'b0;
      r_wr_timeout <= 1'b0;
    end else begin
      r_rd_wdog    <= (r_rd_state == ST_BUSY) ? r_rd_wdog + 1'b1 : '0;
      r_wr_wdog    <= (r_wr_state == ST_BUSY) ? r_wr_wdog + 1'b1 : '0;
      r_rd_timeout <= w_rd_to_fire;
      r_wr_timeout <= w_wr_to_fire;
    end
  end

  assign o_rd_timeout = r_rd_timeout;
  assign o_wr_timeout = r_wr_timeout;
`else
  assign w_rd_wdog_hit = 1'b0;
  assign w_wr_wdog_hit = 1'b0;
  assign o_rd_timeout  = 1'b0;
  assign o_wr_timeout  = 1'b0;
`endif

  assign o_dma_req        = w_rd_req_out;
  assign o_slave_dma_ack  = w_rd_ack_fire ? w_rd_oh : '0;
  assign o_dma_req_addr   = w_addr_arr[r_rd_sel];
  assign o_dma_req_len    = w_len_arr[r_rd_sel];
  assign o_dma_req_tag    = w_tag_arr[r_rd_sel];
  assign o_rd_grant_id    = r_rd_sel;

  assign o_dma_data_avail    = w_wr_avail_out;
  assign o_slave_dma_data_rd = w_wr_rd_fire ? w_wr_oh : '0;
  assign o_slave_dma_done    = w_wr_done_fire ? w_wr_oh : '0;
  assign o_dma_wr_addr       = w_wr_addr_arr[r_wr_sel];
  assign o_dma_len           = w_wr_len_arr[r_wr_sel];
  assign o_dma_data          = w_data_arr[r_wr_sel];
  assign o_wr_grant_id       = r_wr_sel;

endmodule

// File: tb/tb_user_dma_rr_arbiter.sv
// Self-checking bench for user_dma_rr_arbiter: directed vector table, random run against a
// transaction-level model, and hand sequences for reset-in-flight and the watchdog.
module tb_user_dma_rr_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int LW   = 12;
  localparam int TW   = 8;
  localparam int DW   = 64;
  localparam int WL   = 5;
  localparam int WDOG = 8;
`ifdef USER_DMA_ARB_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req, avail;
  logic [N*AW-1:0] addr_p, waddr_p;
  logic [N*LW-1:0] len_p;
  logic [N*TW-1:0] tag_p;
  logic [N*WL-1:0] wlen_p;
  logic [N*DW-1:0] data_p;
  logic            ack, drd, done;

  logic [N-1:0]    o_ack, o_drd, o_done;
  logic            o_req, o_avail, o_rto, o_wto;
  logic [AW-1:0]   o_addr, o_waddr;
  logic [LW-1:0]   o_len;
  logic [TW-1:0]   o_tag;
  logic [DW-1:0]   o_data;
  logic [WL-1:0]   o_wlen;
  logic [1:0]      o_rid, o_wid;

  user_dma_rr_arbiter #(
    .NUM_SLAVES(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .DATA_WIDTH(DW), .DMA_LEN(WL), .WDOG_CYCLES(WDOG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_slave_dma_req(req), .i_slave_dma_addr(addr_p), .i_slave_dma_len(len_p),
    .i_slave_dma_tag(tag_p), .o_slave_dma_ack(o_ack),
    .i_slave_dma_data_avail(avail), .i_slave_dma_wr_addr(waddr_p),
    .i_slave_dma_wr_len(wlen_p), .i_slave_dma_data(data_p),
    .o_slave_dma_data_rd(o_drd), .o_slave_dma_done(o_done),
    .o_dma_req(o_req), .i_dma_ack(ack), .o_dma_req_addr(o_addr),
    .o_dma_req_len(o_len), .o_dma_req_tag(o_tag),
    .o_dma_data_avail(o_avail), .o_dma_wr_addr(o_waddr), .o_dma_data(o_data),
    .o_dma_len(o_wlen), .i_dma_data_rd(drd), .i_dma_done(done),
    .o_rd_grant_id(o_rid), .o_wr_grant_id(o_wid),
    .o_rd_timeout(o_rto), .o_wr_timeout(o_wto)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] f_addr [N];
  logic [LW-1:0] f_len  [N];
  logic [TW-1:0] f_tag  [N];
  logic [AW-1:0] f_waddr[N];
  logic [WL-1:0] f_wlen [N];
  logic [DW-1:0] f_data [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pack_fields();
    for (int k = 0; k < N; k++) begin
      addr_p[k*AW +: AW]  = f_addr[k];
      len_p[k*LW +: LW]   = f_len[k];
      tag_p[k*TW +: TW]   = f_tag[k];
      waddr_p[k*AW +: AW] = f_waddr[k];
      wlen_p[k*WL +: WL]  = f_wlen[k];
      data_p[k*DW +: DW]  = f_data[k];
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit m_rd_busy, m_wr_busy, m_rd_to, m_wr_to;
  int m_rd_sel, m_rd_last, m_rd_cnt, m_wr_sel, m_wr_last, m_wr_cnt;

  logic       e_req, e_avail, e_rto, e_wto;
  logic [3:0] e_ack, e_drd, e_done;
  int         e_rid, e_wid;

  function automatic int next_rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic model_reset();
    m_rd_busy = 0; m_wr_busy = 0; m_rd_to = 0; m_wr_to = 0;
    m_rd_sel = 0; m_wr_sel = 0; m_rd_last = N - 1; m_wr_last = N - 1;
    m_rd_cnt = 0; m_wr_cnt = 0;
  endtask

  task automatic model_outputs();
    e_req   = m_rd_busy && req[m_rd_sel];
    e_ack   = (m_rd_busy && ack) ? 4'(1 << m_rd_sel) : 4'd0;
    e_rid   = m_rd_sel;
    e_avail = m_wr_busy && avail[m_wr_sel];
    e_drd   = (m_wr_busy && drd) ? 4'(1 << m_wr_sel) : 4'd0;
    e_done  = (m_wr_busy && done) ? 4'(1 << m_wr_sel) : 4'd0;
    e_wid   = m_wr_sel;
    e_rto   = m_rd_to;
    e_wto   = m_wr_to;
  endtask

  task automatic model_advance();
    bit rto, wto;
    rto = 0; wto = 0;
    if (!m_rd_busy) begin
      if (req != 0) begin
        m_rd_sel = next_rr(req, m_rd_last); m_rd_last = m_rd_sel;
        m_rd_busy = 1; m_rd_cnt = 0;
      end
    end else if (ack || !req[m_rd_sel]) begin
      m_rd_busy = 0;
    end else if (WD_ON && m_rd_cnt == WDOG - 1) begin
      m_rd_busy = 0; rto = 1;
    end else begin
      m_rd_cnt++;
    end
    if (!m_wr_busy) begin
      if (avail != 0) begin
        m_wr_sel = next_rr(avail, m_wr_last); m_wr_last = m_wr_sel;
        m_wr_busy = 1; m_wr_cnt = 0;
      end
    end else if (done) begin
      m_wr_busy = 0;
    end else if (WD_ON && m_wr_cnt == WDOG - 1) begin
      m_wr_busy = 0; wto = 1;
    end else begin
      m_wr_cnt++;
    end
    m_rd_to = rto; m_wr_to = wto;
  endtask

  // Drive one cycle of inputs away from the active edge and settle.
  task automatic drive(input logic [3:0] rq, input logic ak, input logic [3:0] av,
                       input logic dr, input logic dn);
    @(negedge clk);
    req = rq; ack = ak; avail = av; drd = dr; done = dn;
    #1;
    model_outputs();
  endtask

  task automatic end_cycle();
    model_advance();
    @(posedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".req"},   64'(o_req),   64'(e_req));
    chk({tag, ".ack"},   64'(o_ack),   64'(e_ack));
    chk({tag, ".rid"},   64'(o_rid),   64'(e_rid));
    chk({tag, ".addr"},  64'(o_addr),  64'(f_addr[e_rid]));
    chk({tag, ".tag"},   64'(o_tag),   64'(f_tag[e_rid]));
    chk({tag, ".avail"}, 64'(o_avail), 64'(e_avail));
    chk({tag, ".drd"},   64'(o_drd),   64'(e_drd));
    chk({tag, ".done"},  64'(o_done),  64'(e_done));
    chk({tag, ".wid"},   64'(o_wid),   64'(e_wid));
    chk({tag, ".data"},  o_data,       f_data[e_wid]);
    chk({tag, ".wlen"},  64'(o_wlen),  64'(f_wlen[e_wid]));
    chk({tag, ".rto"},   64'(o_rto),   64'(e_rto));
    chk({tag, ".wto"},   64'(o_wto),   64'(e_wto));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] rq; logic ak; logic [3:0] av; logic dr; logic dn;
    logic x_req; logic [3:0] x_ack; int x_rid;
    logic x_av;  logic [3:0] x_dr;  logic [3:0] x_dn; int x_wid;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [3:0] rq, input logic ak, input logic [3:0] av,
                     input logic dr, input logic dn, input logic x_req, input logic [3:0] x_ack,
                     input int x_rid, input logic x_av, input logic [3:0] x_dr,
                     input logic [3:0] x_dn, input int x_wid);
    vec_t v;
    v = '{rq, ak, av, dr, dn, x_req, x_ack, x_rid, x_av, x_dr, x_dn, x_wid};
    vecs.push_back(v);
  endtask

  initial begin
    int busy_n, to_n, to_at;

    //    rq       ak  av      dr dn | req ack      rid av  drd      done     wid
    add(4'b0100, 0, 4'b0000, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b0100, 0, 4'b0000, 0, 0,  1, 4'b0000, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b0100, 1, 4'b0000, 0, 0,  1, 4'b0100, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 4'b0000, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b1000, 3,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 3,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b0001, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b0010, 1,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 1,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b0100, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 2,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b1000, 3,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 0, 4'b0000, 0, 0,  0, 4'b0000, 3,  0, 4'b0000, 4'b0000, 0);
    add(4'b1111, 1, 4'b0000, 0, 0,  1, 4'b0001, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 0, 4'b0000, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 4'b0000, 1,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 4'b0000, 1,  0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 4'b0000, 0, 0,  0, 4'b0000, 1,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 1, 4'b0000, 0, 0,  0, 4'b0001, 0,  0, 4'b0000, 4'b0000, 0);
    // write burst on slave 1, avail dropped mid-burst, then done
    add(4'b0000, 0, 4'b0010, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0010, 1, 0,  0, 4'b0000, 0,  1, 4'b0010, 4'b0000, 1);
    add(4'b0000, 0, 4'b0010, 0, 0,  0, 4'b0000, 0,  1, 4'b0000, 4'b0000, 1);
    add(4'b0000, 0, 4'b0000, 1, 0,  0, 4'b0000, 0,  0, 4'b0010, 4'b0000, 1);
    add(4'b0000, 0, 4'b0010, 1, 0,  0, 4'b0000, 0,  1, 4'b0010, 4'b0000, 1);
    add(4'b0000, 0, 4'b0010, 1, 0,  0, 4'b0000, 0,  1, 4'b0010, 4'b0000, 1);
    add(4'b0000, 0, 4'b0010, 0, 1,  0, 4'b0000, 0,  1, 4'b0000, 4'b0010, 1);
    add(4'b0000, 0, 4'b0000, 1, 1,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 1);
    // read on slave 3 and write on slave 0 in parallel
    add(4'b1000, 0, 4'b0001, 0, 0,  0, 4'b0000, 0,  0, 4'b0000, 4'b0000, 1);
    add(4'b1000, 1, 4'b0001, 0, 0,  1, 4'b1000, 3,  1, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0001, 0, 1,  0, 4'b0000, 3,  1, 4'b0000, 4'b0001, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,  0, 4'b0000, 3,  0, 4'b0000, 4'b0000, 0);

    for (int k = 0; k < N; k++) begin
      f_addr[k]  = 32'h2000 + 32'(k);
      f_len[k]   = 12'(k + 1);
      f_tag[k]   = 8'h10 + 8'(k);
      f_waddr[k] = 32'h8000_0000 + 32'(k << 8);
      f_wlen[k]  = 5'(k + 3);
      f_data[k]  = 64'hD0D0_0000_0000_0000 | 64'(k);
    end
    f_addr[2] = 32'h1000; f_len[2] = 12'h040; f_tag[2] = 8'h05;
    pack_fields();

    req = '0; avail = '0; ack = 0; drd = 0; done = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req",   64'(o_req),   64'd0);
    chk("reset.avail", 64'(o_avail), 64'd0);
    chk("reset.rid",   64'(o_rid),   64'd0);
    chk("reset.addr",  64'(o_addr),  64'(f_addr[0]));
    chk("reset.rto",   64'(o_rto),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rq, vecs[i].ak, vecs[i].av, vecs[i].dr, vecs[i].dn);
      $display("vec %0d: req=%b ack=%b avail=%b drd=%b done=%b -> o_req=%b o_ack=%b rid=%0d o_avail=%b o_drd=%b o_done=%b wid=%0d",
               i, req, ack, avail, drd, done, o_req, o_ack, o_rid, o_avail, o_drd, o_done, o_wid);
      chk($sformatf("vec%0d.req", i),   64'(o_req),   64'(vecs[i].x_req));
      chk($sformatf("vec%0d.ack", i),   64'(o_ack),   64'(vecs[i].x_ack));
      chk($sformatf("vec%0d.rid", i),   64'(o_rid),   64'(vecs[i].x_rid));
      chk($sformatf("vec%0d.addr", i),  64'(o_addr),  64'(f_addr[vecs[i].x_rid]));
      chk($sformatf("vec%0d.len", i),   64'(o_len),   64'(f_len[vecs[i].x_rid]));
      chk($sformatf("vec%0d.tag", i),   64'(o_tag),   64'(f_tag[vecs[i].x_rid]));
      chk($sformatf("vec%0d.avail", i), 64'(o_avail), 64'(vecs[i].x_av));
      chk($sformatf("vec%0d.drd", i),   64'(o_drd),   64'(vecs[i].x_dr));
      chk($sformatf("vec%0d.done", i),  64'(o_done),  64'(vecs[i].x_dn));
      chk($sformatf("vec%0d.wid", i),   64'(o_wid),   64'(vecs[i].x_wid));
      chk($sformatf("vec%0d.waddr", i), 64'(o_waddr), 64'(f_waddr[vecs[i].x_wid]));
      chk($sformatf("vec%0d.data", i),  o_data,       f_data[vecs[i].x_wid]);
      chk($sformatf("vec%0d.to", i),    64'({o_rto, o_wto}), 64'd0);
      end_cycle();
    end

    // random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        f_addr[k] = $urandom; f_tag[k] = 8'($urandom); f_len[k] = 12'($urandom);
        f_data[k] = {$urandom, $urandom}; f_wlen[k] = 5'($urandom); f_waddr[k] = $urandom;
      end
      pack_fields();
      req = 4'($urandom) | 4'($urandom); avail = 4'($urandom) & 4'($urandom);
      ack = ($urandom_range(0, 2) == 0); drd = 1'($urandom);
      done = ($urandom_range(0, 3) == 0);
      #1;
      model_outputs();
      check_model($sformatf("rnd%0d", c));
      end_cycle();
    end
    $display("random phase: %0d cycles, errors so far %0d", 600, errors);

    // reset asserted while a write is in flight
    drive(4'b0000, 1, 4'b0000, 0, 1); check_model("pre_rst.idle"); end_cycle();
    drive(4'b0000, 0, 4'b0100, 0, 0); check_model("pre_rst.grant"); end_cycle();
    drive(4'b0010, 0, 4'b0100, 1, 0); check_model("pre_rst.busy");
    chk("pre_rst.avail_hi", 64'(o_avail), 64'd1);
    done = 1; ack = 1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.avail", 64'(o_avail), 64'd0);
    chk("rst_mid.drd",   64'(o_drd),   64'd0);
    chk("rst_mid.done",  64'(o_done),  64'd0);
    chk("rst_mid.ack",   64'(o_ack),   64'd0);
    chk("rst_mid.req",   64'(o_req),   64'd0);
    chk("rst_mid.wid",   64'(o_wid),   64'd0);
    req = '0; avail = '0; ack = 0; drd = 0; done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1010, 0, 4'b1010, 0, 0); check_model("post_rst.idle"); end_cycle();
    drive(4'b1010, 0, 4'b1010, 0, 0); check_model("post_rst.busy");
    chk("post_rst.rid", 64'(o_rid), 64'd1);
    chk("post_rst.wid", 64'(o_wid), 64'd1);
    end_cycle();

    // unanswered read request: watchdog release, or indefinite hold without it
    drive(4'b0000, 1, 4'b0000, 0, 1); check_model("wd.idle"); end_cycle();
    drive(4'b0001, 0, 4'b0000, 0, 0); check_model("wd.grant"); end_cycle();
    busy_n = 0; to_n = 0; to_at = -1;
    for (int c = 0; c < 100; c++) begin
      drive(4'b0001, 0, 4'b0000, 0, 0);
      check_model($sformatf("wd%0d", c));
      if (o_req && to_at < 0) busy_n++;
      if (o_rto) begin
        to_n++;
        if (to_at < 0) to_at = c;
      end
      end_cycle();
    end
    if (WD_ON) begin
      chk("wdog.busy_before_timeout", 64'(busy_n), 64'(WDOG));
      chk("wdog.first_timeout_cycle", 64'(to_at),  64'(WDOG));
    end else begin
      chk("nowdog.busy_cycles", 64'(busy_n), 64'd100);
      chk("nowdog.timeouts",    64'(to_n),   64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
